// File: rtl/mux_arb_pkg.sv
// Shared types and the circular priority search for the
// four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Walk downward so the entry closest to ptr wins last.
  function automatic pick_t rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    pick_t      p;
    logic [1:0] i;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (req[i]) begin
        p.found = 1'b1;
        p.idx   = i;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational circular priority encoder: first set
// request at or after ptr, wrapping 3 to 0.
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  pick_t p;

  assign p     = rr_pick(req, ptr);
  assign idx   = p.idx;
  assign found = p.found;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four
// requesters, with a bounded hold time and registered data.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   din,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel_n;
  logic [3:0] gnt_n;
  logic [7:0] hold_cnt, hold_n;

  logic [3:0] own;
  logic [3:0] pick_req;
  logic [1:0] pick_ptr;
  logic [1:0] win;
  logic       found;
  logic       held;
  logic       at_max;

  // While granted, the owner is masked out and the search
  // starts just past it; in IDLE it starts at ptr.
  assign own      = (state == GRANT) ? (4'b0001 << sel) : 4'b0000;
  assign held     = |(req & own);
  assign pick_req = req & ~own;
  assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  assign at_max   = (hold_cnt == HOLD_LIM);
  assign busy     = (state == GRANT);

  rr_priority_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (win),
    .found (found)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          hold_n  = 8'd1;
        end
      end
      GRANT: begin
        if (!held) begin
          ptr_n = sel + 2'd1;
          if (found) begin
            gnt_n  = 4'b0001 << win;
            sel_n  = win;
            hold_n = 8'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            hold_n  = 8'd0;
          end
        end else if (at_max && found) begin
          ptr_n  = sel + 2'd1;
          gnt_n  = 4'b0001 << win;
          sel_n  = win;
          hold_n = 8'd1;
        end else if (!at_max) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      sel        <= 2'd0;
      gnt        <= 4'b0000;
      hold_cnt   <= 8'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      sel        <= sel_n;
      gnt        <= gnt_n;
      hold_cnt   <= hold_n;
      dout_valid <= held;
      if (held)
        dout <= din[int'(sel)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomised and directed bench for mux4_rr_arbiter against
// a behavioural arbitration model.
module tb_mux4_rr_arbiter;

  localparam int DW    = 4;
  localparam int MH    = 4;
  localparam int BOUND = 3 * MH + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: owner index (-1 idle), rotation pointer, hold count
  int          m_own  = -1;
  int          m_ptr  = 0;
  int          m_hold = 0;
  logic [DW-1:0] m_dout = '0;
  logic        m_dv   = 1'b0;
  logic [3:0]  req_s  = '0;
  logic        rst_s  = 1'b0;
  bit          armed  = 0;
  int          wc[4]  = '{0, 0, 0, 0};

  function automatic int search(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] rest;
    req_s = req;
    rst_s = rst_n;
    if (!rst_n) begin
      m_own  = -1;
      m_ptr  = 0;
      m_hold = 0;
      m_dout = '0;
      m_dv   = 1'b0;
      armed  = 1;
    end else begin
      m_dv = (m_own >= 0) && req[m_own];
      if (m_dv) m_dout = din[m_own*DW +: DW];
      rest = (m_own >= 0) ? (req & ~(4'b1 << m_own)) : req;
      if (m_own < 0) begin
        if (req != 0) begin
          m_own  = search(req, m_ptr);
          m_hold = 1;
        end
      end else if (!req[m_own]) begin
        m_ptr = (m_own + 1) % 4;
        if (rest != 0) begin
          m_own  = search(rest, m_ptr);
          m_hold = 1;
        end else begin
          m_own  = -1;
          m_hold = 0;
        end
      end else if (m_hold == MH && rest != 0) begin
        m_ptr  = (m_own + 1) % 4;
        m_own  = search(rest, m_ptr);
        m_hold = 1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  end

  always @(negedge clk) begin
    int wmax;
    if (armed) begin
      check("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : 32'(4'b1 << m_own));
      check("busy", 32'(busy), 32'(m_own >= 0));
      check("dout_valid", 32'(dout_valid), 32'(m_dv));
      check("dout", 32'(dout), 32'(m_dout));
      if (m_own >= 0) check("sel", 32'(sel), 32'(m_own));
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      wmax = 0;
      for (int i = 0; i < 4; i++) begin
        if (rst_s && req_s[i] && !gnt[i]) wc[i]++;
        else wc[i] = 0;
        if (wc[i] > wmax) wmax = wc[i];
      end
      checks++;
      if (wmax > BOUND) begin
        failures++;
        $display("FAIL wait got=%0d exp<=%0d t=%0t", wmax, BOUND, $time);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] gexp;
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = '0;
    repeat (2) tick();
    check("lit_rst_gnt", 32'(gnt), 32'd0);
    check("lit_rst_dv", 32'(dout_valid), 32'd0);
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_dout", 32'(dout), 32'd0);

    rst_n = 1'b1;
    din   = 16'h0500;
    req   = 4'b0100;
    tick();
    check("lit_single_gnt", 32'(gnt), 32'h4);
    check("lit_single_sel", 32'(sel), 32'd2);
    check("lit_single_dv0", 32'(dout_valid), 32'd0);
    tick();
    check("lit_single_dv1", 32'(dout_valid), 32'd1);
    check("lit_single_dout", 32'(dout), 32'h5);
    repeat (3) tick();
    req = 4'b0000;
    tick();
    check("lit_single_idle", 32'(gnt), 32'd0);
    check("lit_single_dvoff", 32'(dout_valid), 32'd0);

    req = 4'b0001;
    tick();
    check("lit_hold_a", 32'(gnt), 32'h1);
    req = 4'b0101;
    repeat (3) begin
      tick();
      check("lit_hold_b", 32'(gnt), 32'h1);
    end
    tick();
    check("lit_hold_rot", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();

    req = 4'b0010;
    tick();
    check("lit_prerst_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    tick();
    check("lit_midrst_gnt", 32'(gnt), 32'd0);
    check("lit_midrst_dv", 32'(dout_valid), 32'd0);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check("lit_postrst_gnt", 32'(gnt), 32'h2);
    check("lit_postrst_sel", 32'(sel), 32'd1);

    req = 4'b0011;
    tick();
    check("lit_b2b_keep", 32'(gnt), 32'h2);
    req = 4'b0001;
    tick();
    check("lit_b2b_gnt", 32'(gnt), 32'h1);
    check("lit_b2b_sel", 32'(sel), 32'd0);
    check("lit_b2b_dv", 32'(dout_valid), 32'd0);

    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      gexp = 4'b0001 << (k % 4);
      check("lit_rr_order", 32'(gnt), 32'(gexp));
      req = 4'b1111 & ~gexp;
    end

    req = 4'b0001;
    repeat (22) begin
      tick();
      check("lit_solo_hold", 32'(gnt), 32'h1);
    end

    for (int n = 0; n < 1000; n++) begin
      rst_n = ($urandom_range(199) != 0);
      if ($urandom_range(2) == 0) req = 4'($urandom);
      din = 16'($urandom);
      tick();
    end

    rst_n = 1'b1;
    req   = 4'b0000;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
